// File: rtl/halfband_interp_poly_if.sv
// +--------------------------------------------------------------------------+
// | halfband_interp_poly_if                                                  |
// | Strobe/sample bundle between a sample source and the halfband            |
// | interpolator.                                                            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface halfband_interp_poly_if #(
  parameter int WIDTH = 18
);
  logic                    sam_clk_en;
  logic                    sys_clk2_en;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y;
  logic                    y_phase;

  modport master (
    output sam_clk_en, sys_clk2_en, x_in,
    input  y, y_phase
  );

  modport slave (
    input  sam_clk_en, sys_clk2_en, x_in,
    output y, y_phase
  );
endinterface

`default_nettype wire

// File: rtl/halfband_interp_poly.sv
// +--------------------------------------------------------------------------+
// | halfband_interp_poly                                                     |
// | 2x polyphase halfband interpolator: 8-tap symmetric odd phase (F) plus   |
// | delayed center pass-through (C). Define HALFBAND_INTERP_SAT_EN for a     |
// | saturating 2s16->1s17 output conversion; wrapping otherwise.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module halfband_interp_poly #(
  parameter int WIDTH   = 18,
  parameter int NTAPS   = 8,
  parameter int CTR_IDX = 3
) (
  input  wire logic             sys_clk,
  input  wire logic             reset,
  halfband_interp_poly_if.slave bus
);

  localparam int NPRE  = NTAPS / 2;
  localparam int NSUM  = NPRE / 2;
  localparam int PW    = 2 * WIDTH;
  // Four center stages put C exactly half a low-rate period after its F sample.
  localparam int NCDLY = 4;

  typedef logic signed [WIDTH-1:0] samp_t;

  function automatic samp_t coef(input int idx);
    case (idx)
      0:       coef = samp_t'(-322);
      1:       coef = samp_t'(3144);
      2:       coef = samp_t'(-15695);
      3:       coef = samp_t'(78408);
      default: coef = '0;
    endcase
  endfunction

  samp_t x_q  [NTAPS];
  samp_t p_q  [NPRE];
  samp_t s2_q [NSUM];
  samp_t s2_d [NSUM];
  samp_t s3_q;
  samp_t s3_d;
  samp_t c_q  [NCDLY];
  samp_t y_q;
  logic  y_phase_q;

  samp_t m_tr [NPRE];
  samp_t f_conv;
  samp_t c_conv;

  // Products are 3s33; the arithmetic shift keeps bits [34:17] as 2s16.
  for (genvar gi = 0; gi < NPRE; gi++) begin : g_mul
    logic signed [PW-1:0] prod;
    assign prod       = coef(gi) * p_q[gi];
    assign m_tr[gi]   = samp_t'(prod >>> (WIDTH - 1));
  end

  always_comb begin
    for (int j = 0; j < NSUM; j++) begin
      s2_d[j] = m_tr[2*j] + m_tr[2*j+1];
    end
    s3_d = '0;
    for (int j = 0; j < NSUM; j++) begin
      s3_d = s3_d + s2_q[j];
    end
  end

`ifdef HALFBAND_INTERP_SAT_EN
  localparam samp_t SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam samp_t SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    if (s3_q[WIDTH-1] != s3_q[WIDTH-2]) begin
      f_conv = s3_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      f_conv = s3_q <<< 1;
    end
  end
`else
  assign f_conv = s3_q <<< 1;
`endif

  // The center branch doubles a halved input, so it cannot overflow.
  assign c_conv = c_q[NCDLY-1] <<< 1;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) x_q[i]  <= '0;
      for (int i = 0; i < NPRE; i++)  p_q[i]  <= '0;
      for (int j = 0; j < NSUM; j++)  s2_q[j] <= '0;
      for (int k = 0; k < NCDLY; k++) c_q[k]  <= '0;
      s3_q      <= '0;
      y_q       <= '0;
      y_phase_q <= 1'b0;
    end else if (bus.sys_clk2_en) begin
      x_q[0] <= bus.x_in >>> 1;
      for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
      for (int i = 0; i < NPRE; i++)  p_q[i] <= x_q[i] + x_q[NTAPS-1-i];
      c_q[0] <= x_q[CTR_IDX];
      for (int k = 1; k < NCDLY; k++) c_q[k] <= c_q[k-1];
      for (int j = 0; j < NSUM; j++)  s2_q[j] <= s2_d[j];
      s3_q      <= s3_d;
      y_q       <= f_conv;
      y_phase_q <= 1'b0;
    end else if (bus.sam_clk_en) begin
      y_q       <= c_conv;
      y_phase_q <= 1'b1;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_phase = y_phase_q;

endmodule

`default_nettype wire
